// File: rtl/spi_sfr_host.sv
// spi_sfr_host: SFR-bus sequencer that drives one spi_ms master (config, byte load, select, poll, readback).
// Define SPI_SFR_HOST_TIMEOUT_EN to bound the WAIT state with a 10-bit timeout counter.
module spi_sfr_host #(
    parameter int unsigned SS_IDX   = 0,
    parameter int unsigned GAP      = 8,
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [7:0]  SPSR_CLR = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_div,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       err_timeout,
    output logic [2:0] sfraddr_w,
    output logic [2:0] sfraddr_r,
    output logic       sfrwe,
    output logic [7:0] spidata_o,
    input  logic [7:0] sfrdatai,
    input  logic       intspi,
    output logic [7:0] spssn_o
);
    localparam int unsigned GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [2:0]  A_SPCR  = 3'h0;
    localparam logic [2:0]  A_SPSR  = 3'h1;
    localparam logic [2:0]  A_SPER  = 3'h2;
    localparam logic [2:0]  A_SPDR  = 3'h3;
    localparam logic [7:0]  SS_MASK = 8'h01 << SS_IDX;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CFG_CTRL, ST_CFG_DIV, ST_LOAD, ST_START,
        ST_WAIT, ST_READ, ST_CAPTURE, ST_HOLD, ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            cfg_done_q, cfg_done_d;
    logic            last_q, last_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            sfrwe_q, sfrwe_d;
    logic [2:0]      sfraddr_w_q, sfraddr_w_d;
    logic [2:0]      sfraddr_r_q, sfraddr_r_d;
    logic [7:0]      spidata_q, spidata_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic [7:0]      ssn_q, ssn_d;
    logic            sel_off;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
    localparam int unsigned TW = 10;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    assign sel_off     = |(ssn_q & SS_MASK);
    assign tx_ready    = (state_q == ST_IDLE) && cfg_done_q && !cfg_wr;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign sfrwe       = sfrwe_q;
    assign sfraddr_w   = sfraddr_w_q;
    assign sfraddr_r   = sfraddr_r_q;
    assign spidata_o   = spidata_q;
    assign spssn_o     = ssn_q;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Next state; SFR outputs are registered from the state being entered.
    always_comb begin
        state_d     = state_q;
        cfg_done_d  = cfg_done_q;
        last_d      = last_q;
        gap_d       = gap_q;
        sfrwe_d     = 1'b0;
        sfraddr_w_d = sfraddr_w_q;
        sfraddr_r_d = sfraddr_r_q;
        spidata_d   = spidata_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        ssn_d       = ssn_q;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_wr && sel_off) begin
                    state_d     = ST_CFG_CTRL;
                    sfrwe_d     = 1'b1;
                    sfraddr_w_d = A_SPCR;
                    spidata_d   = {1'b0, 1'b1, 1'b0, 1'b1, cfg_mode, 2'b00};
                end else if (tx_valid && tx_ready) begin
                    state_d     = ST_LOAD;
                    last_d      = tx_last;
                    sfrwe_d     = 1'b1;
                    sfraddr_w_d = A_SPDR;
                    spidata_d   = tx_data;
                end
            end
            ST_CFG_CTRL: begin
                state_d     = ST_CFG_DIV;
                sfrwe_d     = 1'b1;
                sfraddr_w_d = A_SPER;
                spidata_d   = cfg_div;
            end
            ST_CFG_DIV: begin
                state_d    = ST_IDLE;
                cfg_done_d = 1'b1;
            end
            ST_LOAD: begin
                state_d = ST_START;
                ssn_d   = ssn_q & ~SS_MASK;
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (intspi) begin
                    state_d     = ST_READ;
                    sfraddr_r_d = A_SPDR;
                end
`ifdef SPI_SFR_HOST_TIMEOUT_EN
                // Give up on a transfer that never completes; the byte is dropped.
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d     = ST_GAP;
                    gap_d       = '0;
                    err_d       = 1'b1;
                    sfrwe_d     = 1'b1;
                    sfraddr_w_d = A_SPSR;
                    spidata_d   = SPSR_CLR;
                    ssn_d       = 8'hFF;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            ST_READ: begin
                state_d     = ST_CAPTURE;
                sfrwe_d     = 1'b1;
                sfraddr_w_d = A_SPSR;
                spidata_d   = SPSR_CLR;
            end
            ST_CAPTURE: begin
                state_d    = ST_HOLD;
                rx_valid_d = 1'b1;
                rx_data_d  = sfrdatai;
            end
            ST_HOLD: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                        ssn_d   = 8'hFF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
                else                       gap_d   = gap_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_done_q  <= 1'b0;
            last_q      <= 1'b0;
            gap_q       <= '0;
            sfrwe_q     <= 1'b0;
            sfraddr_w_q <= '0;
            sfraddr_r_q <= '0;
            spidata_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            ssn_q       <= 8'hFF;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_done_q  <= cfg_done_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            sfrwe_q     <= sfrwe_d;
            sfraddr_w_q <= sfraddr_w_d;
            sfraddr_r_q <= sfraddr_r_d;
            spidata_q   <= spidata_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            ssn_q       <= ssn_d;
`ifdef SPI_SFR_HOST_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_sfr_host.sv
// Bench for spi_sfr_host: behavioural spi_ms SFR responder, table vectors, random frames, scoreboard.
`timescale 1ns/1ps
module tb_spi_sfr_host;
    localparam int unsigned GAP      = 8;
    localparam int unsigned TIMEOUT  = 1023;
    localparam logic [7:0]  SPSR_CLR = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_mode = 2'b00;
    logic [7:0] cfg_div = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       err_timeout;
    logic [2:0] sfraddr_w, sfraddr_r;
    logic       sfrwe;
    logic [7:0] spidata_o, sfrdatai, spssn_o;
    logic       intspi;

    spi_sfr_host #(.SS_IDX(0), .GAP(GAP), .TIMEOUT(TIMEOUT), .SPSR_CLR(SPSR_CLR)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .err_timeout(err_timeout),
        .sfraddr_w(sfraddr_w), .sfraddr_r(sfraddr_r), .sfrwe(sfrwe), .spidata_o(spidata_o),
        .sfrdatai(sfrdatai), .intspi(intspi), .spssn_o(spssn_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] reply;
        logic       last;
        int         int_dly;
        int         rdy_dly;
        logic       cfg_with;
        logic       cfg_mid;
    } vec_t;

    // Behavioural spi_ms: logs SFR writes, raises intspi some cycles after an SPDR write.
    logic       intspi_r = 1'b0;
    logic       int_glitch = 1'b0;
    bit         no_int = 1'b0;
    int         int_dly = 4;
    int         int_cnt = 0;
    int         cyc = 0;
    int         int_cyc = 0;
    int         n_ctrl_wr = 0;
    logic [7:0] reply_cur = 8'h00;
    logic [2:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] slave_rx[$];
    logic [7:0] sent[$];
    logic [7:0] exp_rx[$];
    logic [7:0] got_rx[$];

    assign intspi   = intspi_r | int_glitch;
    assign sfrdatai = (sfraddr_r == 3'h3) ? reply_cur : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            intspi_r <= 1'b0;
            int_cnt  <= 0;
        end else begin
            if (sfrwe) begin
                wa_q.push_back(sfraddr_w);
                wd_q.push_back(spidata_o);
                if (sfraddr_w == 3'h0) n_ctrl_wr <= n_ctrl_wr + 1;
                if (sfraddr_w == 3'h3) slave_rx.push_back(spidata_o);
                if (sfraddr_w == 3'h1) intspi_r <= 1'b0;
            end
            if (sfrwe && sfraddr_w == 3'h3) begin
                int_cnt <= int_dly;
            end else if (int_cnt > 0) begin
                int_cnt <= int_cnt - 1;
                if (int_cnt == 1 && !no_int) begin
                    intspi_r <= 1'b1;
                    int_cyc  <= cyc + 1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [1:0] m, input logic [7:0] d);
        int nc;
        nc = n_ctrl_wr;
        cfg_mode = m; cfg_div = d; cfg_wr = 1'b1;
        #1;
        chk("cfg_cycle_tx_ready", 32'(tx_ready), 0);
        tick(); cfg_wr = 1'b0; #1;
        chk("spcr_we", 32'(sfrwe), 1);
        chk("spcr_addr", 32'(sfraddr_w), 0);
        chk("spcr_data", 32'(spidata_o), 32'(8'h50 | (8'(m) << 2)));
        tick(); #1;
        chk("sper_we", 32'(sfrwe), 1);
        chk("sper_addr", 32'(sfraddr_w), 2);
        chk("sper_data", 32'(spidata_o), 32'(d));
        tick(); #1;
        chk("cfg_tx_ready", 32'(tx_ready), 1);
        chk("cfg_we_idle", 32'(sfrwe), 0);
        chk("cfg_ctrl_count", 32'(n_ctrl_wr - nc), 1);
    endtask

    task automatic send_byte(input vec_t v);
        int n;
        int nc;
        int w0;
        if (v.cfg_mid) begin
            nc = n_ctrl_wr;
            cfg_wr = 1'b1; #1;
            chk("mid_cfg_tx_ready", 32'(tx_ready), 0);
            tick(); cfg_wr = 1'b0;
            repeat (3) tick();
            #1;
            chk("mid_cfg_ignored", 32'(n_ctrl_wr - nc), 0);
            chk("mid_cfg_sel", 32'(spssn_o), 32'hFE);
        end
        nc = n_ctrl_wr;
        reply_cur = v.reply; int_dly = v.int_dly;
        tx_valid = 1'b1; tx_data = v.data; tx_last = v.last; cfg_wr = v.cfg_with;
        #1;
        n = 0;
        while (!tx_ready && n < 100) begin
            tick(); cfg_wr = 1'b0; #1; n++;
        end
        if (v.cfg_with) begin
            chk("cfg_tx_accept_wait", 32'(n), 3);
            chk("cfg_tx_ctrl_count", 32'(n_ctrl_wr - nc), 1);
        end
        chk("tx_ready_wait", 32'(tx_ready), 1);
        if (!tx_ready) begin tx_valid = 1'b0; return; end
        tick(); tx_valid = 1'b0; #1;
        chk("spdr_we", 32'(sfrwe), 1);
        chk("spdr_addr", 32'(sfraddr_w), 3);
        chk("spdr_data", 32'(spidata_o), 32'(v.data));
        tick(); #1;
        chk("start_sel", 32'(spssn_o), 32'hFE);
        n = 0;
        while (!rx_valid && n < 200) begin tick(); #1; n++; end
        chk("rx_valid_wait", 32'(rx_valid), 1);
        if (!rx_valid) return;
        chk("rx_latency", 32'(cyc - int_cyc), 3);
        chk("rx_data", 32'(rx_data), 32'(v.reply));
        chk("spsr_clr_addr", 32'(wa_q[$]), 1);
        chk("spsr_clr_data", 32'(wd_q[$]), 32'(SPSR_CLR));
        w0 = wa_q.size();
        for (int i = 0; i < v.rdy_dly; i++) begin
            tick(); #1;
            chk("hold_valid", 32'(rx_valid), 1);
            chk("hold_data", 32'(rx_data), 32'(v.reply));
            chk("hold_sel", 32'(spssn_o), 32'hFE);
            chk("hold_no_write", 32'(wa_q.size()), 32'(w0));
        end
        got_rx.push_back(rx_data); exp_rx.push_back(v.reply); sent.push_back(v.data);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0; #1;
        chk("rx_valid_drop", 32'(rx_valid), 0);
        if (v.last) begin
            chk("end_sel", 32'(spssn_o), 32'hFF);
            n = 0;
            while (!tx_ready && n < 50) begin tick(); #1; n++; end
            chk("gap_len", 32'(n), 32'(GAP));
            chk("gap_sel", 32'(spssn_o), 32'hFF);
        end else begin
            chk("mid_sel", 32'(spssn_o), 32'hFE);
            chk("mid_tx_ready", 32'(tx_ready), 1);
        end
    endtask

    vec_t tbl[5];

    initial begin
        int w0;
        int n;
        int t0;
        tbl[0] = '{8'hA5, 8'h3C, 1'b1, 4,  0, 1'b0, 1'b0};
        tbl[1] = '{8'h11, 8'h81, 1'b0, 3,  1, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 8'h82, 1'b0, 6, 20, 1'b0, 1'b1};
        tbl[3] = '{8'h33, 8'h83, 1'b1, 2,  0, 1'b0, 1'b0};
        tbl[4] = '{8'h5A, 8'hC3, 1'b1, 5,  2, 1'b1, 1'b0};

        repeat (3) tick();
        #1;
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_we", 32'(sfrwe), 0);
        chk("rst_addr_w", 32'(sfraddr_w), 0);
        chk("rst_addr_r", 32'(sfraddr_r), 0);
        chk("rst_data", 32'(spidata_o), 0);
        chk("rst_ssn", 32'(spssn_o), 32'hFF);
        rst_n = 1'b1;
        tick();

        do_cfg(2'b00, 8'h03);

        for (int i = 0; i < 5; i++) begin
            send_byte(tbl[i]);
            if (i == 0) chk("slave_got_a5", 32'(slave_rx[$]), 32'hA5);
        end

        // Stray intspi while idle must not start a readback.
        w0 = wa_q.size();
        int_glitch = 1'b1;
        repeat (3) tick();
        int_glitch = 1'b0;
        tick(); #1;
        chk("stray_int_rx", 32'(rx_valid), 0);
        chk("stray_int_wr", 32'(wa_q.size()), 32'(w0));
        chk("stray_int_ready", 32'(tx_ready), 1);

        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, 4);
            do_cfg(2'($urandom), 8'($urandom));
            for (int b = 0; b < len; b++) begin
                vec_t v;
                v.data     = 8'($urandom);
                v.reply    = 8'($urandom);
                v.last     = (b == len - 1);
                v.int_dly  = $urandom_range(2, 12);
                v.rdy_dly  = $urandom_range(0, 3);
                v.cfg_with = 1'b0;
                v.cfg_mid  = (b > 0) && ($urandom_range(0, 3) == 0);
                send_byte(v);
            end
        end

`ifdef SPI_SFR_HOST_TIMEOUT_EN
        no_int = 1'b1; int_dly = 3;
        tx_valid = 1'b1; tx_data = 8'h77; tx_last = 1'b1;
        #1;
        chk("tmo_tx_ready", 32'(tx_ready), 1);
        t0 = cyc;
        tick(); tx_valid = 1'b0; #1;
        sent.push_back(8'h77);
        n = 0;
        while (!err_timeout && !rx_valid && n < 1200) begin tick(); #1; n++; end
        chk("tmo_pulse", 32'(err_timeout), 1);
        chk("tmo_latency", 32'(cyc - t0), 32'(3 + TIMEOUT));
        chk("tmo_clr_we", 32'(sfrwe), 1);
        chk("tmo_clr_addr", 32'(sfraddr_w), 1);
        chk("tmo_clr_data", 32'(spidata_o), 32'(SPSR_CLR));
        chk("tmo_sel", 32'(spssn_o), 32'hFF);
        chk("tmo_no_rx", 32'(rx_valid), 0);
        tick(); #1;
        chk("tmo_one_shot", 32'(err_timeout), 0);
        n = 1;
        while (!tx_ready && n < 50) begin
            if (rx_valid) chk("tmo_gap_no_rx", 32'(rx_valid), 0);
            tick(); #1; n++;
        end
        chk("tmo_gap_len", 32'(n), 32'(GAP));
        no_int = 1'b0;
`else
        chk("err_tied_low", 32'(err_timeout), 0);
`endif

        // Reset while a byte is in flight.
        no_int = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h99; tx_last = 1'b0;
        tick(); tx_valid = 1'b0;
        sent.push_back(8'h99);
        tick(); #1;
        chk("pre_rst_sel", 32'(spssn_o), 32'hFE);
        rst_n = 1'b0;
        tick(); #1;
        chk("mid_rst_ssn", 32'(spssn_o), 32'hFF);
        chk("mid_rst_we", 32'(sfrwe), 0);
        chk("mid_rst_addr_w", 32'(sfraddr_w), 0);
        chk("mid_rst_data", 32'(spidata_o), 0);
        chk("mid_rst_rx_valid", 32'(rx_valid), 0);
        rst_n = 1'b1; no_int = 1'b0;
        tick(); #1;
        chk("mid_rst_unconfigured", 32'(tx_ready), 0);
        do_cfg(2'b11, 8'h10);
        send_byte('{8'h42, 8'h24, 1'b1, 3, 0, 1'b0, 1'b0});

        chk("sb_rx_count", 32'(got_rx.size()), 32'(exp_rx.size()));
        for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
            chk("sb_rx_byte", 32'(got_rx[i]), 32'(exp_rx[i]));
        chk("sb_tx_count", 32'(slave_rx.size()), 32'(sent.size()));
        for (int i = 0; i < slave_rx.size() && i < sent.size(); i++)
            chk("sb_tx_byte", 32'(slave_rx[i]), 32'(sent[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sfr_host.md
# spi_sfr_host

SFR-bus host sequencer that drives one `spi_ms` instance in master mode through its SFR write/read interface. Sits between a byte-stream client and `spi_ms`: it programs the control and divider registers, loads each transmit byte, drives slave select, waits for `intspi`, reads back the received byte, and clears the status flag. It is the initiator for the SFR port that `spi_ms` responds to.

## Interface
Parameters:
- `SS_IDX`, default 0: `spssn_o` bit used as the slave select.
- `GAP`, default 8: idle cycles with select deasserted after a frame ends.
- `TIMEOUT`, default 1023: maximum cycles spent in WAIT.
- `SPSR_CLR`, default 8'h01: value written to SPSR (addr 3'h1) to clear the transfer flag.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_wr` in 1: pulse that requests (re)configuration.
- `cfg_mode` in 2: {CPOL, CPHA}.
- `cfg_div` in 8: value for SPER (addr 3'h2).
- `tx_valid` in 1, `tx_ready` out 1, `tx_data` in 8, `tx_last` in 1: transmit byte stream. `tx_last` ends the frame.
- `rx_valid` out 1, `rx_ready` in 1, `rx_data` out 8: received byte stream.
- `err_timeout` out 1: one-cycle pulse on timeout.
- `sfraddr_w` out 3, `sfraddr_r` out 3, `sfrwe` out 1, `spidata_o` out 8: connect to `spi_ms` `sfraddr_w`/`sfraddr_r`/`sfrwe`/`spidata_i`.
- `sfrdatai` in 8: from `spi_ms.sfrdatao`.
- `intspi` in 1: from `spi_ms.intspi`.
- `spssn_o` out 8: to `spi_ms.spssn_i`.

## Operation
- Register map: 3'h0 SPCR ([6] SPE, [4] MSTR, [3] CPOL, [2] CPHA), 3'h1 SPSR, 3'h2 SPER, 3'h3 SPDR.
- SPCR write data is `{1'b0,1'b1,1'b0,1'b1,cfg_mode,2'b00}`.
- FSM states: IDLE, CFG_CTRL, CFG_DIV, LOAD, START, WAIT, READ, CAPTURE, HOLD, GAP.
- IDLE:
  - If `cfg_wr` is high and select is deasserted, go to CFG_CTRL. Config wins over a simultaneous `tx_valid`, and `tx_ready` is 0 in that cycle.
  - `cfg_wr` is ignored while select is asserted or outside IDLE.
  - `tx_ready` = configured flag AND no `cfg_wr`. On handshake, latch `tx_data` and `tx_last` and go to LOAD.
- CFG_CTRL: `sfrwe`=1, addr 0, SPCR data. Then CFG_DIV: `sfrwe`=1, addr 2, `cfg_div`. Set the configured flag and return to IDLE.
- LOAD: `sfrwe`=1, `sfraddr_w`=3, `spidata_o`=byte.
- START: drive `spssn_o[SS_IDX]`=0; all other bits stay 1. Reset the timeout counter.
- WAIT: leave on `intspi`=1 and go to READ.
- READ: `sfraddr_r`=3.
- CAPTURE:
  - Register `sfrdatai` into `rx_data` and assert `rx_valid`.
  - Issue the SPSR clear write in the same cycle (`sfrwe`=1, addr 1, `SPSR_CLR`).
  - Go to HOLD.
- HOLD: keep `rx_valid` until `rx_ready`. When accepted:
  - if the latched last bit is set, deassert select and go to GAP;
  - otherwise return to IDLE with select still asserted.
- GAP: count `GAP` cycles, then go to IDLE.
- `sfrwe` is 0 in every cycle not listed above. `sfraddr_*` and `spidata_o` hold their last value.

## Timing
- Reset values: `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `err_timeout`=0, `sfrwe`=0, `sfraddr_w`=0, `sfraddr_r`=0, `spidata_o`=0, `spssn_o`=8'hFF. Configured flag and counters reset to 0.
- Configuration: `cfg_wr` sampled at cycle C gives SPCR write at C+1, SPER write at C+2, and `tx_ready`=1 at C+3.
- Transmit: handshake at cycle T gives SPDR write at T+1 and select low at T+2.
- Receive: `intspi` seen at cycle I gives `rx_valid`=1 at I+3 (READ at I+1, CAPTURE at I+2, output registered).
- Frame end: with last set and `rx_ready`=1 at I+3, select is high at I+4. `tx_ready` returns at I+4+`GAP`.
- Reset mid-transfer: all outputs return to their reset values on the next edge, and the configured flag clears.
- `intspi` outside WAIT is ignored.

## Configuration
- `SPI_SFR_HOST_TIMEOUT_EN` defined:
  - A 10-bit counter increments in WAIT.
  - On reaching `TIMEOUT` with no `intspi`: pulse `err_timeout` for one cycle, write `SPSR_CLR`, deassert select, discard the byte (no `rx_valid`), and go to GAP.
  - The rest of the frame is dropped, and the client restarts the frame.
- Undefined: WAIT is unbounded, `err_timeout` is tied 0, and the counter is absent.

## Test plan
- Reset, then `cfg_wr` with mode 2'b00 and div 8'h03 -> SFR writes addr0=8'h50 then addr2=8'h03 on consecutive cycles; `tx_ready` high 3 cycles after `cfg_wr`.
- Single byte 8'hA5 with `tx_last`=1, looped to a `spi_ms` slave preloaded with 8'h3C -> `rx_data`=8'h3C, `spssn_o`=8'hFE during transfer, back to 8'hFF after, slave receives 8'hA5.
- Three-byte frame, last only on byte 3 -> `spssn_o[0]` stays low across all three bytes; three `rx_valid` pulses; exactly one GAP of 8 cycles at the end.
- `rx_ready` held low 20 cycles after CAPTURE -> `rx_valid` and `rx_data` stable, select stays asserted, no new SPDR write until accepted.
- With `SPI_SFR_HOST_TIMEOUT_EN` and `intspi` forced 0 -> `err_timeout` pulse after 1023 WAIT cycles, SPSR clear write, select high, no `rx_valid`.
- `cfg_wr` while select is asserted mid-frame -> ignored, no SPCR write; `cfg_wr` and `tx_valid` together in IDLE -> config performed first, byte accepted 3 cycles later.
